// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the mux4 round-robin arbiter
//
// Purpose: source count, select width, arbiter state encoding and the
//          index-to-one-hot helper used for the grant vector.
// Ports:   none (package).
package arb_pkg;

  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_SRC-1:0] onehot4(input logic [SEL_W-1:0] idx);
    onehot4 = NUM_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotating first-set picker over four requests
//
// Purpose: returns the first set request bit found when searching upward from
//          start with wrap 3->0, so the bit just below start is searched last.
// Ports:
//   req      in   4  request vector
//   start    in   2  first index examined
//   winner   out  2  index of the selected request (0 when none)
//   any_req  out  1  at least one request bit is set
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   start,
  output logic [SEL_W-1:0]   winner,
  output logic               any_req
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      // Index arithmetic is modulo 4 by width, which gives the wrap for free.
      idx = start + SEL_W'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mux4_arbiter.sv
// rtl/mux4_arbiter.sv - round-robin select controller for a 4:1 datapath mux
//
// Purpose: drives the 2-bit select of a downstream mux4 from four request
//          lines, presents the selected word with valid/ready and returns a
//          one-hot grant to the source whose word was consumed. Every transfer
//          is followed by one IDLE cycle that samples fresh requests.
// Optional feature: define MUX4_ARBITER_BURST_EN to let the last-served source
//          win up to MAX_BURST consecutive transfers before round robin resumes.
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  synchronous active-low reset
//   req        in   4  per-source request, held until granted
//   out_ready  in   1  downstream accepts the current word
//   sel        out  2  registered mux select
//   out_valid  out  1  registered word-valid
//   gnt        out  4  combinational one-hot ack of the consumed source
module mux4_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   sel,
  output logic               out_valid,
  output logic [NUM_SRC-1:0] gnt
);

  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("mux4_arbiter: MAX_BURST must be at least 1");
  end

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [SEL_W-1:0] rr_start;
  logic [SEL_W-1:0] rr_winner;
  logic             rr_any;
  logic             xfer;

`ifdef MUX4_ARBITER_BURST_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Search starts one past the last served source, so it is considered last.
  assign rr_start = last_q + SEL_W'(1);

  rr_pick4 u_pick (
    .req     (req),
    .start   (rr_start),
    .winner  (rr_winner),
    .any_req (rr_any)
  );

  assign xfer = (state_q == GRANT) && out_ready;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
`ifdef MUX4_ARBITER_BURST_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (rr_any) begin
`ifdef MUX4_ARBITER_BURST_EN
          // A zero count means nobody has been served since reset, so the
          // reset value of last must not be treated as a burst in progress.
          if (req[last_q] && (cnt_q != '0) && (cnt_q < CNT_W'(MAX_BURST))) begin
            sel_d = last_q;
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            sel_d = rr_winner;
            cnt_d = CNT_W'(1);
          end
`else
          sel_d = rr_winner;
`endif
          state_d = GRANT;
        end
      end
      GRANT: begin
        // sel is frozen and req is ignored until the word is taken.
        if (out_ready) begin
          last_d  = sel_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_SRC - 1);
`ifdef MUX4_ARBITER_BURST_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
`ifdef MUX4_ARBITER_BURST_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign sel       = sel_q;
  assign out_valid = (state_q == GRANT);
  // Gated by rst_n so a word pending at reset is dropped without an ack.
  assign gnt       = (rst_n && xfer) ? onehot4(sel_q) : '0;

endmodule

// File: tb/tb_mux4_arbiter.sv
// tb/tb_mux4_arbiter.sv - scoreboard bench for the mux4 round-robin arbiter
module tb_mux4_arbiter;
  import arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;
  logic [1:0] sel;
  logic       out_valid;
  logic [3:0] gnt;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [1:0] exp_q[$];

  mux4_arbiter #(.MAX_BURST(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .gnt       (gnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Pops one expected select per observed transfer; idle cycles must not ack.
  task automatic drain(input int budget, input bit clear, input bit chk_gap);
    int         k = 0;
    int         last_xfer = -1;
    logic [1:0] e;
    logic [3:0] gmask;
    while (exp_q.size() > 0 && k < budget) begin
      @(negedge clk);
      gmask = 4'b0000;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        check("xfer_sel", 32'(sel), 32'(e));
        check("xfer_gnt", 32'(gnt), 32'(onehot4(e)));
        if (chk_gap && last_xfer >= 0) check("xfer_gap", 32'(cyc - last_xfer), 32'd2);
        last_xfer = cyc;
        gmask = gnt;
      end else begin
        check("idle_gnt", 32'(gnt), 32'd0);
      end
      next_cycle();
      if (clear) req = req & ~gmask;
      k++;
    end
    if (exp_q.size() > 0) begin
      check("timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b1;

    // Reset held with all requests up.
    repeat (3) begin
      @(negedge clk);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_gnt", 32'(gnt), 32'd0);
      next_cycle();
    end
    rst_n = 1'b1;
    exp_q.push_back(2'd0);
    drain(10, 1'b1, 1'b0);
    req = 4'b0000;
    next_cycle();
    next_cycle();

    // Single request: valid one cycle after req, idle right after the transfer.
    req = 4'b0001;
    out_ready = 1'b1;
    @(negedge clk);
    check("sr_c1_valid", 32'(out_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("sr_c2_valid", 32'(out_valid), 32'd1);
    check("sr_c2_sel", 32'(sel), 32'd0);
    check("sr_c2_gnt", 32'(gnt), 32'b0001);
    next_cycle();
    req = 4'b0000;
    @(negedge clk);
    check("sr_c3_valid", 32'(out_valid), 32'd0);
    check("sr_c3_gnt", 32'(gnt), 32'd0);
    next_cycle();

    // Fresh reset, then sustained requests.
    rst_n = 1'b0;
    req   = 4'b0000;
    next_cycle();
    rst_n = 1'b1;
`ifdef MUX4_ARBITER_BURST_EN
    req = 4'b0011;
    foreach (exp_q[i]) ;
    exp_q.push_back(2'd0); exp_q.push_back(2'd0);
    exp_q.push_back(2'd1); exp_q.push_back(2'd1);
    exp_q.push_back(2'd0); exp_q.push_back(2'd0);
`else
    req = 4'b1111;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
`endif
    drain(40, 1'b0, 1'b1);
    req = 4'b0000;
    next_cycle();
    next_cycle();

    // Backpressure on source 2 while requests toggle.
    out_ready = 1'b0;
    req = 4'b0100;
    next_cycle();
    @(negedge clk);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_sel", 32'(sel), 32'd2);
    repeat (5) begin
      next_cycle();
      req = 4'($urandom_range(0, 15));
      @(negedge clk);
      check("bp_hold_sel", 32'(sel), 32'd2);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_gnt", 32'(gnt), 32'd0);
    end
    next_cycle();
    req = 4'b0100;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_gnt", 32'(gnt), 32'b0100);
    next_cycle();
    req = 4'b0000;
    @(negedge clk);
    check("bp_after_valid", 32'(out_valid), 32'd0);
    next_cycle();

    // Reset while source 3 holds a pending word.
    out_ready = 1'b0;
    req = 4'b1000;
    next_cycle();
    @(negedge clk);
    check("rm_valid", 32'(out_valid), 32'd1);
    check("rm_sel", 32'(sel), 32'd3);
    rst_n = 1'b0;
    out_ready = 1'b1;
    req = 4'b1010;
    #1;
    check("rm_gnt_in_reset", 32'(gnt), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check("rm_after_valid", 32'(out_valid), 32'd0);
    check("rm_after_gnt", 32'(gnt), 32'd0);
    next_cycle();
    out_ready = 1'b1;
    exp_q.push_back(2'd1);
    drain(10, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
